// File: rtl/flippy_column_array.sv
// Falling-target column tracker for Flippy Bit: COLUMNS targets share one drop timer
// that speeds up after each correct guess. States: IDLE wait start | PLAYING dropping | OVER frozen.
module flippy_column_array #(
  parameter int COLUMNS   = 4,
  parameter int WIDTH     = 8,
  parameter int ROWS      = 22,
  parameter int YPOS_W    = 5,
  parameter int TICK_INIT = 50000000,
  parameter int TICK_MIN  = 10000000,
  parameter int TICK_STEP = 1000000,
  parameter int DELAY_W   = 26
) (
  input  logic                      clock,
  input  logic                      reset_signal,
  input  logic                      start,
  input  logic [WIDTH-1:0]          user_input,
  input  logic                      user_valid,
  output logic [COLUMNS*YPOS_W-1:0] ypos,
  output logic [COLUMNS*WIDTH-1:0]  letter,
  output logic [COLUMNS-1:0]        active,
  output logic                      playing,
  output logic                      game_over,
  output logic                      correct,
  output logic [15:0]               score
);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAYING, ST_OVER} state_t;

  localparam logic [YPOS_W-1:0]  Y_BOT     = YPOS_W'(ROWS - 1);
  localparam logic [DELAY_W-1:0] P_INIT    = DELAY_W'(TICK_INIT);
  localparam logic [DELAY_W-1:0] P_MIN     = DELAY_W'(TICK_MIN);
  localparam logic [DELAY_W-1:0] P_STEP    = DELAY_W'(TICK_STEP);
  localparam logic [DELAY_W-1:0] P_FLOOR   = DELAY_W'(TICK_MIN + TICK_STEP);
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;
  localparam logic [15:0]        LFSR_MASK = 16'hB400;

  state_t                           state_q, state_d;
  logic [COLUMNS-1:0][YPOS_W-1:0]   ypos_q, ypos_d;
  logic [COLUMNS-1:0][WIDTH-1:0]    letter_q, letter_d;
  logic [COLUMNS-1:0]               active_q, active_d;
  logic                             playing_q, playing_d;
  logic                             game_over_q, game_over_d;
  logic                             correct_q, correct_d;
  logic [15:0]                      score_q, score_d;
  logic [15:0]                      lfsr_q, lfsr_d;
  logic [DELAY_W-1:0]               count_q, count_d;
  logic [DELAY_W-1:0]               period_q, period_d;
  logic                             hit, tick, bottom, spawned;

  always_comb begin
    state_d     = state_q;
    ypos_d      = ypos_q;
    letter_d    = letter_q;
    active_d    = active_q;
    playing_d   = playing_q;
    game_over_d = game_over_q;
    correct_d   = 1'b0;
    score_d     = score_q;
    count_d     = count_q;
    period_d    = period_q;
    hit         = 1'b0;
    bottom      = 1'b0;
    spawned     = 1'b0;
    lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    tick        = (state_q == ST_PLAYING) && (count_q >= period_q - DELAY_W'(1));

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAYING;
          playing_d   = 1'b1;
          game_over_d = 1'b0;
          score_d     = '0;
          count_d     = '0;
          period_d    = P_INIT;
          ypos_d      = '0;
          active_d    = '0;
          active_d[0] = 1'b1;
          letter_d[0] = lfsr_q[WIDTH-1:0];
        end
      end
      ST_PLAYING: begin
        if (user_valid) begin
          for (int i = 0; i < COLUMNS; i++) begin
            if (!hit && active_q[i] && (letter_q[i] == user_input)) begin
              hit         = 1'b1;
              active_d[i] = 1'b0;
              ypos_d[i]   = '0;
            end
          end
        end
        if (hit) begin
          correct_d = 1'b1;
          score_d   = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
          period_d  = (period_q >= P_FLOOR) ? period_q - P_STEP : P_MIN;
        end
        // The hit is resolved before the tick so a just-hit bottom column cannot end the game.
        if (tick) begin
          count_d = '0;
          for (int i = 0; i < COLUMNS; i++) begin
            if (active_d[i] && (ypos_d[i] == Y_BOT)) bottom = 1'b1;
          end
          if (bottom) begin
            state_d     = ST_OVER;
            playing_d   = 1'b0;
            game_over_d = 1'b1;
          end else begin
            for (int i = 0; i < COLUMNS; i++) begin
              if (active_d[i]) ypos_d[i] = ypos_d[i] + YPOS_W'(1);
            end
            for (int i = 0; i < COLUMNS; i++) begin
              if (!spawned && !active_d[i]) begin
                spawned     = 1'b1;
                active_d[i] = 1'b1;
                ypos_d[i]   = '0;
                letter_d[i] = lfsr_q[WIDTH-1:0];
              end
            end
          end
        end else begin
          count_d = count_q + DELAY_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state_q     <= ST_IDLE;
      ypos_q      <= '0;
      letter_q    <= '0;
      active_q    <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      correct_q   <= 1'b0;
      score_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      count_q     <= '0;
      period_q    <= P_INIT;
    end else begin
      state_q     <= state_d;
      ypos_q      <= ypos_d;
      letter_q    <= letter_d;
      active_q    <= active_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
      correct_q   <= correct_d;
      score_q     <= score_d;
      lfsr_q      <= lfsr_d;
      count_q     <= count_d;
      period_q    <= period_d;
    end
  end

  assign ypos      = ypos_q;
  assign letter    = letter_q;
  assign active    = active_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign correct   = correct_q;
  assign score     = score_q;

endmodule

// File: tb/tb_flippy_column_array.sv
// Bench for flippy_column_array: hand-derived scenario table plus random play,
// every cycle compared against a behavioural game model.
module tb_flippy_column_array;

  localparam int COLS  = 2;
  localparam int W     = 8;
  localparam int ROWS  = 4;
  localparam int YW    = 5;
  localparam int TINIT = 10;
  localparam int TMIN  = 4;
  localparam int TSTEP = 2;

  logic                 clock;
  logic                 reset_signal;
  logic                 start;
  logic [W-1:0]         user_input;
  logic                 user_valid;
  logic [COLS*YW-1:0]   ypos;
  logic [COLS*W-1:0]    letter;
  logic [COLS-1:0]      active;
  logic                 playing;
  logic                 game_over;
  logic                 correct;
  logic [15:0]          score;

  flippy_column_array #(
    .COLUMNS(COLS), .WIDTH(W), .ROWS(ROWS), .YPOS_W(YW),
    .TICK_INIT(TINIT), .TICK_MIN(TMIN), .TICK_STEP(TSTEP), .DELAY_W(8)
  ) dut (
    .clock(clock), .reset_signal(reset_signal), .start(start),
    .user_input(user_input), .user_valid(user_valid),
    .ypos(ypos), .letter(letter), .active(active), .playing(playing),
    .game_over(game_over), .correct(correct), .score(score)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the game
  int         m_ypos[COLS];
  logic [7:0] m_letter[COLS];
  bit         m_active[COLS];
  bit         m_playing, m_over, m_correct;
  int         m_score, m_period, m_count;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    for (int i = 0; i < COLS; i++) begin
      m_ypos[i] = 0; m_letter[i] = 8'h00; m_active[i] = 1'b0;
    end
    m_playing = 0; m_over = 0; m_correct = 0;
    m_score = 0; m_period = TINIT; m_count = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_start();
    m_playing = 1; m_over = 0; m_score = 0; m_count = 0; m_period = TINIT;
    for (int i = 0; i < COLS; i++) begin
      m_active[i] = 1'b0; m_ypos[i] = 0;
    end
    m_active[0] = 1'b1;
    m_letter[0] = m_lfsr[7:0];
  endtask

  task automatic model_edge(bit st, bit uv, logic [7:0] ui);
    logic [15:0] nl;
    int hit_col;
    int old_period;
    bit at_bottom;
    bit did_spawn;
    nl = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_correct = 0;
    if (!m_playing) begin
      if (st) model_start();
    end else begin
      hit_col = -1;
      old_period = m_period;
      if (uv) begin
        for (int i = 0; i < COLS; i++)
          if (hit_col < 0 && m_active[i] && m_letter[i] == ui) hit_col = i;
      end
      if (hit_col >= 0) begin
        m_active[hit_col] = 1'b0;
        m_ypos[hit_col] = 0;
        m_correct = 1;
        if (m_score < 65535) m_score++;
        m_period = (m_period - TSTEP > TMIN) ? m_period - TSTEP : TMIN;
      end
      if (m_count >= old_period - 1) begin
        m_count = 0;
        at_bottom = 0;
        for (int i = 0; i < COLS; i++)
          if (m_active[i] && m_ypos[i] == ROWS - 1) at_bottom = 1;
        if (at_bottom) begin
          m_playing = 0; m_over = 1;
        end else begin
          for (int i = 0; i < COLS; i++)
            if (m_active[i]) m_ypos[i]++;
          did_spawn = 0;
          for (int i = 0; i < COLS; i++) begin
            if (!did_spawn && !m_active[i]) begin
              did_spawn = 1; m_active[i] = 1'b1; m_ypos[i] = 0; m_letter[i] = m_lfsr[7:0];
            end
          end
        end
      end else begin
        m_count++;
      end
    end
    m_lfsr = nl;
  endtask

  task automatic check_model(string name);
    logic [COLS*YW-1:0] ey;
    logic [COLS*W-1:0]  el;
    logic [COLS-1:0]    ea;
    for (int i = 0; i < COLS; i++) begin
      ey[i*YW +: YW] = YW'(m_ypos[i]);
      el[i*W +: W]   = m_letter[i];
      ea[i]          = m_active[i];
    end
    vectors++;
    if (ypos !== ey || letter !== el || active !== ea || playing !== m_playing ||
        game_over !== m_over || correct !== m_correct || score !== 16'(m_score)) begin
      miscompares++;
      $display("FAIL %s: got ypos=%h letter=%h active=%b playing=%b over=%b correct=%b score=%0d; want ypos=%h letter=%h active=%b playing=%b over=%b correct=%b score=%0d",
               name, ypos, letter, active, playing, game_over, correct, score,
               ey, el, ea, m_playing, m_over, m_correct, m_score);
    end
  endtask

  task automatic step(bit st, bit uv, logic [7:0] ui, string name);
    start = st; user_valid = uv; user_input = ui;
    @(posedge clock);
    if (reset_signal) model_edge(st, uv, ui);
    else model_reset();
    #1;
    check_model(name);
    start = 1'b0; user_valid = 1'b0;
  endtask

  // sel: 0 none, 1 letter of column 0, 2 letter of column 1, 3 value matching no active column
  function automatic logic [7:0] pick_guess(int sel);
    logic [7:0] g;
    bit clash;
    bit found;
    g = 8'h00;
    if (sel == 1) g = m_letter[0];
    else if (sel == 2) g = m_letter[1];
    else if (sel == 3) begin
      g = ~m_letter[0];
      found = 0;
      for (int k = 0; k < 256; k++) begin
        if (!found) begin
          clash = 0;
          for (int i = 0; i < COLS; i++)
            if (m_active[i] && m_letter[i] == g) clash = 1;
          if (!clash) found = 1;
          else g = g + 8'd1;
        end
      end
    end
    return g;
  endfunction

  typedef struct {
    bit         st;
    bit         uv;
    int         sel;
    int         idle;
    bit         p;
    bit         o;
    logic [1:0] a;
    int         y0;
    int         y1;
    int         sc;
    bit         c;
  } vec_t;

  vec_t tbl[20];

  task automatic check_table(int r);
    logic [COLS*YW-1:0] ey;
    ey = {YW'(tbl[r].y1), YW'(tbl[r].y0)};
    vectors++;
    if (playing !== tbl[r].p || game_over !== tbl[r].o || active !== tbl[r].a ||
        ypos !== ey || score !== 16'(tbl[r].sc) || correct !== tbl[r].c) begin
      miscompares++;
      $display("FAIL tbl[%0d]: got playing=%b over=%b active=%b ypos=%h score=%0d correct=%b; want playing=%b over=%b active=%b ypos=%h score=%0d correct=%b",
               r, playing, game_over, active, ypos, score, correct,
               tbl[r].p, tbl[r].o, tbl[r].a, ey, tbl[r].sc, tbl[r].c);
    end
  endtask

  initial begin
    //            st uv sel idle  p  o  a      y0 y1 sc c
    tbl[0]  = '{1, 0, 0, 0,   1, 0, 2'b01, 0, 0, 0, 0};  // start
    tbl[1]  = '{0, 0, 0, 9,   1, 0, 2'b11, 1, 0, 0, 0};  // first tick, column 1 spawns
    tbl[2]  = '{0, 0, 0, 9,   1, 0, 2'b11, 2, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 0,   1, 0, 2'b10, 0, 1, 1, 1};  // hit column 0, period 8
    tbl[4]  = '{0, 1, 3, 0,   1, 0, 2'b10, 0, 1, 1, 0};  // wrong guess
    tbl[5]  = '{0, 1, 2, 0,   1, 0, 2'b00, 0, 0, 2, 1};  // hit column 1, period 6
    tbl[6]  = '{0, 0, 0, 2,   1, 0, 2'b01, 0, 0, 2, 0};
    tbl[7]  = '{0, 1, 1, 0,   1, 0, 2'b00, 0, 0, 3, 1};  // period 4
    tbl[8]  = '{0, 0, 0, 2,   1, 0, 2'b01, 0, 0, 3, 0};
    tbl[9]  = '{0, 1, 1, 0,   1, 0, 2'b00, 0, 0, 4, 1};  // saturated at 4
    tbl[10] = '{0, 0, 0, 2,   1, 0, 2'b01, 0, 0, 4, 0};
    tbl[11] = '{0, 1, 1, 0,   1, 0, 2'b00, 0, 0, 5, 1};
    tbl[12] = '{0, 0, 0, 2,   1, 0, 2'b01, 0, 0, 5, 0};
    tbl[13] = '{0, 0, 0, 11,  1, 0, 2'b11, 3, 2, 5, 0};  // column 0 at bottom row
    tbl[14] = '{0, 0, 0, 3,   0, 1, 2'b11, 3, 2, 5, 0};  // bottom event
    tbl[15] = '{0, 1, 1, 5,   0, 1, 2'b11, 3, 2, 5, 0};  // frozen, guess ignored
    tbl[16] = '{1, 0, 0, 0,   1, 0, 2'b01, 0, 0, 0, 0};  // restart
    tbl[17] = '{0, 0, 0, 29,  1, 0, 2'b11, 3, 2, 0, 0};
    tbl[18] = '{1, 0, 0, 8,   1, 0, 2'b11, 3, 2, 0, 0};  // start ignored while playing
    tbl[19] = '{0, 1, 1, 0,   1, 0, 2'b11, 0, 3, 1, 1};  // hit at bottom on tick cycle

    reset_signal = 1'b0; start = 1'b1; user_valid = 1'b1; user_input = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_model("reset_hold");
    start = 1'b0; user_valid = 1'b0; reset_signal = 1'b1;

    step(1'b0, 1'b0, 8'h00, "idle");
    for (int r = 0; r < 20; r++) begin
      step(tbl[r].st, tbl[r].uv, pick_guess(tbl[r].sel), "tbl_step");
      for (int k = 0; k < tbl[r].idle; k++) step(1'b0, 1'b0, 8'h00, "tbl_idle");
      check_table(r);
    end

    for (int n = 0; n < 600; n++) begin
      bit st, uv;
      logic [7:0] ui;
      st = ($urandom_range(0, 39) == 0);
      uv = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) ui = m_letter[$urandom_range(0, 1)];
      else ui = 8'($urandom);
      step(st, uv, ui, "random");
    end

    step(1'b1, 1'b0, 8'h00, "pre_reset");
    repeat (5) step(1'b0, 1'b0, 8'h00, "pre_reset");
    #2 reset_signal = 1'b0;
    #1;
    model_reset();
    check_model("reset_async");
    step(1'b1, 1'b0, 8'h00, "reset_held");
    reset_signal = 1'b1;
    step(1'b1, 1'b0, 8'h00, "post_reset_start");
    for (int n = 0; n < 40; n++)
      step(1'b0, $urandom_range(0, 2) == 0, m_letter[$urandom_range(0, 1)], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
